// File: rtl/kick_pkg.sv
// rtl/kick_pkg.sv - shared types and constants for the kicker sequencer
package kick_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHARGE,
        FIRE,
        COOLDOWN,
        FAULT
    } state_t;

    localparam int STRENGTH_W = 7;
    localparam int COUNT_W    = 16;

    // Registered drive pattern per state: {charge_en, kick_pulse, busy, fault}
    function automatic logic [3:0] drive_of(input state_t s);
        case (s)
            CHARGE:   drive_of = 4'b1010;
            FIRE:     drive_of = 4'b0110;
            COOLDOWN: drive_of = 4'b0010;
            FAULT:    drive_of = 4'b0011;
            default:  drive_of = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/kick_sequencer_sync_2ff.sv
// rtl/kick_sequencer_sync_2ff.sv - two-flop synchronizer for asynchronous inputs
module sync_2ff #(
    parameter int         WIDTH     = 1,
    parameter logic [0:0] RESET_VAL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= {WIDTH{RESET_VAL}};
            q    <= {WIDTH{RESET_VAL}};
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/kick_sequencer.sv
// rtl/kick_sequencer.sv - kicker charge/fire/cooldown sequencer with timeout fault
// Optional fire counter port kick_count when KICK_COUNT_EN is defined.
module kick_sequencer
    import kick_pkg::*;
#(
    parameter int PULSE_UNIT_CYC     = 500,
    parameter int CHARGE_TIMEOUT_CYC = 50000000,
    parameter int COOLDOWN_CYC       = 5000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  charge_flag,
    input  logic [STRENGTH_W-1:0] kick_charge,
    input  logic                  cap_full,
    input  logic                  fault_clr,
    output logic                  charge_en,
    output logic                  kick_pulse,
    output logic                  busy,
    output logic                  fault
`ifdef KICK_COUNT_EN
    ,
    output logic [COUNT_W-1:0]    kick_count
`endif
);

    localparam int TO_W = $clog2(CHARGE_TIMEOUT_CYC + 1);
    localparam int PW_W = $clog2(127 * PULSE_UNIT_CYC + 1);
    localparam int CD_W = $clog2(COOLDOWN_CYC + 1);
    localparam int CW_A = (TO_W > PW_W) ? TO_W : PW_W;
    localparam int CW   = (CW_A > CD_W) ? CW_A : CD_W;

    state_t                state;
    logic                  flag_q;
    logic                  cap_full_s;
    logic                  pending;
    logic [STRENGTH_W-1:0] pend_strength;
    logic [STRENGTH_W-1:0] strength;
    logic [CW-1:0]         cnt;
    logic [CW-1:0]         pulse_last;
    logic                  request;

    sync_2ff #(.WIDTH(1), .RESET_VAL(1'b0)) u_cap_sync (
        .clk   (clk),
        .reset (reset),
        .d     (cap_full),
        .q     (cap_full_s)
    );

    assign request    = charge_flag && !flag_q && (kick_charge != '0);
    assign pulse_last = CW'(strength) * CW'(PULSE_UNIT_CYC) - CW'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            flag_q        <= 1'b1;
            pending       <= 1'b0;
            pend_strength <= '0;
            strength      <= '0;
            cnt           <= '0;
            {charge_en, kick_pulse, busy, fault} <= 4'b0000;
`ifdef KICK_COUNT_EN
            kick_count    <= '0;
`endif
        end else begin
            flag_q <= charge_flag;

            // Requests during an active kick are buffered; later case arms may clear it.
            if (request && (state == CHARGE || state == FIRE || state == COOLDOWN)) begin
                pending       <= 1'b1;
                pend_strength <= kick_charge;
            end

            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (pending) begin
                        strength <= pend_strength;
                        pending  <= 1'b0;
                        state    <= CHARGE;
                        {charge_en, kick_pulse, busy, fault} <= drive_of(CHARGE);
                    end else if (request) begin
                        strength <= kick_charge;
                        state    <= CHARGE;
                        {charge_en, kick_pulse, busy, fault} <= drive_of(CHARGE);
                    end
                end
                CHARGE: begin
                    cnt <= cnt + CW'(1);
                    if (cap_full_s) begin
                        cnt   <= '0;
                        state <= FIRE;
                        {charge_en, kick_pulse, busy, fault} <= drive_of(FIRE);
                    end else if (cnt == CW'(CHARGE_TIMEOUT_CYC - 1)) begin
                        cnt     <= '0;
                        pending <= 1'b0;
                        state   <= FAULT;
                        {charge_en, kick_pulse, busy, fault} <= drive_of(FAULT);
                    end else if (!charge_flag) begin
                        cnt     <= '0;
                        pending <= 1'b0;
                        state   <= IDLE;
                        {charge_en, kick_pulse, busy, fault} <= drive_of(IDLE);
                    end
                end
                FIRE: begin
                    cnt <= cnt + CW'(1);
                    if (cnt == pulse_last) begin
                        cnt   <= '0;
                        state <= COOLDOWN;
                        {charge_en, kick_pulse, busy, fault} <= drive_of(COOLDOWN);
`ifdef KICK_COUNT_EN
                        if (kick_count != {COUNT_W{1'b1}})
                            kick_count <= kick_count + COUNT_W'(1);
`endif
                    end
                end
                COOLDOWN: begin
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(COOLDOWN_CYC - 1)) begin
                        cnt   <= '0;
                        state <= IDLE;
                        {charge_en, kick_pulse, busy, fault} <= drive_of(IDLE);
                    end
                end
                FAULT: begin
                    cnt     <= '0;
                    pending <= 1'b0;
                    if (fault_clr) begin
                        state <= IDLE;
                        {charge_en, kick_pulse, busy, fault} <= drive_of(IDLE);
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= IDLE;
                    {charge_en, kick_pulse, busy, fault} <= drive_of(IDLE);
                end
            endcase
        end
    end

endmodule
